// File: rtl/mem_pkg.sv
// Shared constants and sizing helpers for the data memory controller.
package mem_pkg;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  // Sizes for the default configuration (32-bit words, 8 words, latency 2)
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_BYTES   = DEF_DATA_W / 8;

  // Bytes per word
  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Byte-offset bits inside a word
  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index bits
  function automatic int idx_w_of(input int depth);
    return $clog2(depth);
  endfunction

  // Counter bits able to hold LATENCY
  function automatic int cnt_w_of(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port word array with per-byte write enables and a registered read port.
module sp_ram_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-masked write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int k = 0; k < BYTES; k++) begin
        if (be[k]) mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

  // Read register only loads on an enabled read, so it holds between reads
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory for the MEM stage: req/ready/ack handshake,
// programmable latency, misalignment and range checking.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [DATA_W/8-1:0]  be_i,
  output logic                 ready_o,
  output logic                 ack_o,
  output logic [DATA_W-1:0]    rdata_o,
  output logic                 err_o
);

  localparam int BYTES   = bytes_of(DATA_W);
  localparam int OFF_W   = off_w_of(DATA_W);
  localparam int IDX_W   = idx_w_of(DEPTH);
  localparam int CNT_W   = cnt_w_of(LATENCY);
  localparam int LIM_W   = ADDR_W + 1;
  localparam logic [LIM_W-1:0]  LIMIT    = LIM_W'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [BYTES-1:0]    be_reg;
  logic                err_reg;

  logic                accept, commit, misaligned, out_of_range, op_err;
  logic                op_we;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic [BYTES-1:0]    op_be;

  assign accept = req_i && (state_reg != WAIT);

  // With single-cycle latency the access happens on the accept edge itself,
  // so it must use the live request rather than the latched copy.
  assign op_we    = (LATENCY == 1) ? we_i    : we_reg;
  assign op_addr  = (LATENCY == 1) ? addr_i  : addr_reg;
  assign op_wdata = (LATENCY == 1) ? wdata_i : wdata_reg;
  assign op_be    = (LATENCY == 1) ? be_i    : be_reg;

  assign misaligned   = |(op_addr & OFF_MASK);
  assign out_of_range = {1'b0, op_addr} >= LIMIT;
  assign op_err       = misaligned || out_of_range;

  // The access takes effect on the edge that enters RESP
  assign commit = ((state_reg == WAIT) && (cnt_reg == CNT_W'(1))) ||
                  (accept && (LATENCY == 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (req_i) state_next = (LATENCY == 1) ? RESP : WAIT;
        else       state_next = IDLE;
      end
      WAIT: begin
        if (cnt_reg == CNT_W'(1)) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready_o = (state_reg != WAIT);
    ack_o   = (state_reg == RESP);
    err_o   = (state_reg == RESP) && err_reg;
  end

  // Request latch, latency counter and error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg    <= we_i;
        addr_reg  <= addr_i;
        wdata_reg <= wdata_i;
        be_reg    <= be_i;
        cnt_reg   <= CNT_LOAD;
      end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (commit) err_reg <= op_err;
    end
  end

  // Faulting accesses and reset both suppress the array access
  sp_ram_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (commit && !op_err && !rst_i),
    .we    (op_we),
    .be    (op_be),
    .addr  (op_addr[OFF_W +: IDX_W]),
    .wdata (op_wdata),
    .rdata (rdata_o)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: stimulus pushes expected acks; a negedge monitor checks them.
module tb_data_mem_ctrl;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req3 = 0, we3 = 0, ready3, ack3, err3;
  logic [31:0] addr3 = 0, wdata3 = 0, rdata3;
  logic [3:0]  be3 = 0;

  logic        req1 = 0, we1 = 0, ready1, ack1, err1;
  logic [31:0] addr1 = 0, wdata1 = 0, rdata1;
  logic [3:0]  be1 = 0;

  exp_t        q3[$];
  exp_t        q1[$];
  logic [31:0] lr3 = 0, lr1 = 0;
  int          neg_cnt = 0;
  int          probe_req = 0, probe_done = 0;
  int          n_vec = 0, n_miss = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we3), .addr_i(addr3),
    .wdata_i(wdata3), .be_i(be3), .ready_o(ready3), .ack_o(ack3),
    .rdata_o(rdata3), .err_o(err3)
  );

  data_mem_ctrl #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .be_i(be1), .ready_o(ready1), .ack_o(ack1),
    .rdata_o(rdata1), .err_o(err1)
  );

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, neg_cnt);
    end else begin
      $display("ok   %s = %h (cycle %0d)", nm, act, neg_cnt);
    end
  endfunction

  // Monitor: pops one expectation per ack and checks idle/reset state on request
  always @(negedge clk) begin
    exp_t e;
    neg_cnt = neg_cnt + 1;
    if (probe_req != probe_done) begin
      probe_done = probe_req;
      cmp("idle_ready3", {31'd0, ready3}, 32'd1);
      cmp("idle_ack3",   {31'd0, ack3},   32'd0);
      cmp("idle_err3",   {31'd0, err3},   32'd0);
      cmp("idle_rdata3", rdata3,          32'd0);
      cmp("idle_ready1", {31'd0, ready1}, 32'd1);
      cmp("idle_ack1",   {31'd0, ack1},   32'd0);
      cmp("idle_err1",   {31'd0, err1},   32'd0);
      cmp("idle_rdata1", rdata1,          32'd0);
    end
    if (q3.size() > 0 && q3[0].cyc == neg_cnt) begin
      e = q3.pop_front();
      cmp("ack3", {31'd0, ack3}, 32'd1);
      if (ack3 === 1'b1) begin
        cmp("err3",   {31'd0, err3}, {31'd0, e.err});
        cmp("rdata3", rdata3, e.data);
      end
    end else if (ack3 === 1'b1) begin
      cmp("spurious_ack3", {31'd0, ack3}, 32'd0);
    end else if (q3.size() > 0 && ready3 === 1'b1) begin
      cmp("wait_ready3", {31'd0, ready3}, 32'd0);
    end else if (err3 === 1'b1) begin
      cmp("err_no_ack3", {31'd0, err3}, 32'd0);
    end
    if (q1.size() > 0 && q1[0].cyc == neg_cnt) begin
      e = q1.pop_front();
      cmp("ack1", {31'd0, ack1}, 32'd1);
      if (ack1 === 1'b1) begin
        cmp("err1",   {31'd0, err1}, {31'd0, e.err});
        cmp("rdata1", rdata1, e.data);
      end
    end else if (ack1 === 1'b1) begin
      cmp("spurious_ack1", {31'd0, ack1}, 32'd0);
    end else if (err1 === 1'b1) begin
      cmp("err_no_ack1", {31'd0, err1}, 32'd0);
    end
  end

  // Wait for ready, present a request, and push its expected ack
  task automatic issue(input bit s, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input bit e, input logic [31:0] rd, input bit track);
    int   t;
    exp_t x;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!((s ? ready1 : ready3) === 1'b1) && t < 40);
    if ((s ? ready1 : ready3) !== 1'b1) begin
      $display("FAIL issue_timeout: ready stayed %b, want 1", s ? ready1 : ready3);
      $fatal(1);
    end
    if (s) begin
      req1 = 1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
    end else begin
      req3 = 1; we3 = w; addr3 = a; wdata3 = d; be3 = b;
    end
    @(posedge clk);
    if (track) begin
      if (!w && !e) begin
        if (s) lr1 = rd;
        else   lr3 = rd;
      end
      x.err  = e;
      x.data = s ? lr1 : lr3;
      x.cyc  = neg_cnt + (s ? 1 : 3);
      if (s) q1.push_back(x);
      else   q3.push_back(x);
    end
  endtask

  // Drop req once the controller is ready again
  task automatic idle(input bit s);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!((s ? ready1 : ready3) === 1'b1) && t < 40);
    if ((s ? ready1 : ready3) !== 1'b1) begin
      $display("FAIL idle_timeout: ready stayed %b, want 1", s ? ready1 : ready3);
      $fatal(1);
    end
    if (s) req1 = 0;
    else   req3 = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    probe_req++;

    // Full write then read back
    issue(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 1); idle(0);
    issue(0, 0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1); idle(0);
    issue(0, 1, 32'h0, 32'h0BADC0DE, 4'hF, 0, 0, 1); idle(0);

    // Partial byte-enable write
    issue(0, 1, 32'h8, 32'h11223344, 4'b0101, 0, 0, 1); idle(0);
    issue(0, 0, 32'h8, 32'h0, 4'h0, 0, 32'hDE22BE44, 1); idle(0);

    // Misaligned read, out-of-range write, then confirm word 0 untouched
    issue(0, 0, 32'h6, 32'h0, 4'h0, 1, 0, 1); idle(0);
    issue(0, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 1, 0, 1); idle(0);
    issue(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0BADC0DE, 1); idle(0);

    // Back-to-back with req held high
    issue(0, 1, 32'h0, 32'h11111111, 4'hF, 0, 0, 1);
    issue(0, 1, 32'h4, 32'h22222222, 4'hF, 0, 0, 1);
    issue(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h11111111, 1);
    issue(0, 0, 32'h4, 32'h0, 4'h0, 0, 32'h22222222, 1);
    idle(0);

    // Reset during WAIT aborts the write
    issue(0, 1, 32'h4, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    @(negedge clk);
    rst = 1; req3 = 0;
    @(negedge clk);
    rst = 0;
    lr3 = 0;
    lr1 = 0;
    @(posedge clk); #1;
    probe_req++;
    @(negedge clk);
    issue(0, 0, 32'h4, 32'h0, 4'h0, 0, 32'h22222222, 1); idle(0);

    // Inputs wiggle while busy; transaction must be unaffected
    issue(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h11111111, 1);
    @(negedge clk);
    req3 = 0; addr3 = 32'h4;
    @(negedge clk);
    req3 = 1; we3 = 1; addr3 = 32'h8; wdata3 = 32'hFFFFFFFF; be3 = 4'hF;
    idle(0);
    issue(0, 0, 32'h8, 32'h0, 4'h0, 0, 32'hDE22BE44, 1); idle(0);

    // Single-cycle latency, back-to-back
    issue(1, 1, 32'h0, 32'h12345678, 4'hF, 0, 0, 1);
    issue(1, 1, 32'h4, 32'h9ABCDEF0, 4'hF, 0, 0, 1);
    issue(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h12345678, 1);
    issue(1, 0, 32'h4, 32'h0, 4'h0, 0, 32'h9ABCDEF0, 1);
    issue(1, 0, 32'h2, 32'h0, 4'h0, 1, 0, 1);
    idle(1);

    repeat (8) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
